// File: rtl/hw2_result_decoder_if.sv
// hw2_result_decoder_if
//   Bundles the job-input and result-output handshakes of the hw2 result decoder.
//   master: producer/consumer side (drives the job, accepts the result).
//   slave : decoder side.
// Signals:
//   in_valid/in_ready : job handshake for d, b, c, s
//   d                 : MAC result (W_D bits)
//   b, c              : operand b and divisor c (W_OP bits)
//   s                 : 1 when d = (a + b) * c, 0 when d = (a - b) * c
//   out_valid/out_ready : result handshake
//   a_out, rem        : recovered a and remainder of d / c
//   exact, err_div0   : result quality flags
interface hw2_result_decoder_if #(
  parameter int unsigned W_OP = 8,
  parameter int unsigned W_D  = 16
) ();

  logic            in_valid;
  logic            in_ready;
  logic [W_D-1:0]  d;
  logic [W_OP-1:0] b;
  logic [W_OP-1:0] c;
  logic            s;

  logic            out_valid;
  logic            out_ready;
  logic [W_OP-1:0] a_out;
  logic [W_OP-1:0] rem;
  logic            exact;
  logic            err_div0;

  modport master (
    output in_valid, d, b, c, s, out_ready,
    input  in_ready, out_valid, a_out, rem, exact, err_div0
  );

  modport slave (
    input  in_valid, d, b, c, s, out_ready,
    output in_ready, out_valid, a_out, rem, exact, err_div0
  );

endinterface

// File: rtl/hw2_result_decoder.sv
// hw2_result_decoder
//   Recovers operand a of the hw2 MAC from its result: d = (a +/- b) * c.
//   A restoring divider computes q = d / c over W_D cycles, then one fix-up cycle
//   forms a = q -/+ b. Valid/ready handshake on both the job and result sides.
// Ports:
//   clk   : rising-edge clock
//   reset : asynchronous active-low reset
//   bus   : hw2_result_decoder_if.slave (job inputs, result outputs, handshakes)
// Timing: accept edge to out_valid is W_D+2 cycles, or 1 cycle when c == 0.
module hw2_result_decoder #(
  parameter int unsigned W_OP = 8,
  parameter int unsigned W_D  = 16
) (
  input logic                clk,
  input logic                reset,
  hw2_result_decoder_if.slave bus
);

  localparam int unsigned CntW = $clog2(W_D);

  typedef enum logic [1:0] {
    StIdle,
    StDiv,
    StFix,
    StDone
  } state_e;

  state_e          state_q;
  logic [CntW-1:0] cnt_q;

  // q_q starts as the dividend and is shifted out MSB first while quotient bits shift in.
  logic [W_D-1:0]  q_q;
  logic [W_OP:0]   r_q;
  logic [W_OP-1:0] b_q;
  logic [W_OP-1:0] c_q;
  logic            s_q;

  logic            in_ready_q;
  logic            out_valid_q;
  logic [W_OP-1:0] a_out_q;
  logic [W_OP-1:0] rem_q;
  logic            exact_q;
  logic            err_div0_q;

  // One restoring division step.
  logic [W_OP:0]   r_shift;
  logic            step_ge;
  logic [W_OP:0]   r_step;
  logic [W_D-1:0]  q_step;

  // Fix-up results.
  logic [W_OP-1:0] a_fix;
  logic            q_fits;

  always_comb begin
    // r < c <= 2^W_OP - 1 after every step, so its low W_OP bits hold the whole value.
    r_shift = {r_q[W_OP-1:0], q_q[W_D-1]};
    step_ge = (r_shift >= {1'b0, c_q});
    r_step  = step_ge ? (r_shift - {1'b0, c_q}) : r_shift;
    q_step  = {q_q[W_D-2:0], step_ge};
  end

  always_comb begin
    a_fix  = s_q ? (q_q[W_OP-1:0] - b_q) : (q_q[W_OP-1:0] + b_q);
    // Quotient of a genuine (a +/- b) lies below 2^(W_OP+1).
    q_fits = ((q_q >> (W_OP + 1)) == '0);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= StIdle;
      cnt_q       <= '0;
      q_q         <= '0;
      r_q         <= '0;
      b_q         <= '0;
      c_q         <= '0;
      s_q         <= 1'b0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      a_out_q     <= '0;
      rem_q       <= '0;
      exact_q     <= 1'b0;
      err_div0_q  <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (bus.in_valid && in_ready_q) begin
            b_q        <= bus.b;
            c_q        <= bus.c;
            s_q        <= bus.s;
            q_q        <= bus.d;
            r_q        <= '0;
            cnt_q      <= '0;
            in_ready_q <= 1'b0;
            if (bus.c == '0) begin
              // a is not recoverable; report immediately.
              err_div0_q <= 1'b1;
              a_out_q    <= '0;
              rem_q      <= '0;
              exact_q    <= 1'b0;
              state_q    <= StDone;
            end else begin
              state_q <= StDiv;
            end
          end
        end

        StDiv: begin
          q_q   <= q_step;
          r_q   <= r_step;
          cnt_q <= cnt_q + 1'b1;
          if (cnt_q == CntW'(W_D - 1)) begin
            state_q <= StFix;
          end
        end

        StFix: begin
          a_out_q    <= a_fix;
          rem_q      <= r_q[W_OP-1:0];
          exact_q    <= (r_q == '0) && q_fits;
          err_div0_q <= 1'b0;
          state_q    <= StDone;
        end

        StDone: begin
          // out_valid rises one cycle after entering DONE and holds until taken.
          if (!out_valid_q) begin
            out_valid_q <= 1'b1;
          end else if (bus.out_ready) begin
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            state_q     <= StIdle;
          end
        end

        default: begin
          state_q <= StIdle;
        end
      endcase
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.a_out     = a_out_q;
  assign bus.rem       = rem_q;
  assign bus.exact     = exact_q;
  assign bus.err_div0  = err_div0_q;

endmodule

// File: tb/tb_hw2_result_decoder.sv
module tb_hw2_result_decoder;

  localparam int unsigned W_OP = 8;
  localparam int unsigned W_D  = 16;

  logic clk   = 1'b0;
  logic reset = 1'b0;

  always #5 clk = ~clk;

  hw2_result_decoder_if #(.W_OP(W_OP), .W_D(W_D)) bus ();

  hw2_result_decoder #(.W_OP(W_OP), .W_D(W_D)) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic [15:0] d;
    logic [7:0]  b;
    logic [7:0]  c;
    logic        s;
    logic [7:0]  a_exp;
    logic [7:0]  rem_exp;
    logic        exact_exp;
    logic        err_exp;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Reference: plain integer division and the MAC inversion rule.
  function automatic void model(input logic [15:0] d, input logic [7:0] b, input logic [7:0] c,
                                input logic s, output logic [7:0] a, output logic [7:0] r,
                                output logic ex, output logic e0);
    int unsigned q;
    int unsigned rr;
    if (c == 8'd0) begin
      a = 8'd0; r = 8'd0; ex = 1'b0; e0 = 1'b1;
    end else begin
      q  = int'(d) / int'(c);
      rr = int'(d) % int'(c);
      a  = 8'(s ? (q - int'(b)) : (q + int'(b)));
      r  = 8'(rr);
      ex = (rr == 0) && (q < 512);
      e0 = 1'b0;
    end
  endfunction

  // Drives one job, checks latency and result, optionally holds out_ready low for
  // 'hold' cycles (pulsing in_valid when 'pulse' is set), then retires the result.
  task automatic run_job(input string tag, input logic [15:0] d, input logic [7:0] b,
                         input logic [7:0] c, input logic s, input logic [7:0] ea,
                         input logic [7:0] er, input logic ex, input logic e0,
                         input int hold, input bit pulse);
    int cyc;
    int exp_lat;
    exp_lat = e0 ? 1 : int'(W_D) + 2;
    cyc = 0;
    while (bus.in_ready !== 1'b1 && cyc < 50) begin
      @(posedge clk); #1; cyc++;
    end
    chk({tag, " in_ready before accept"}, 32'(bus.in_ready), 1);
    bus.d = d; bus.b = b; bus.c = c; bus.s = s; bus.in_valid = 1'b1;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    chk({tag, " in_ready after accept"}, 32'(bus.in_ready), 0);
    cyc = 0;
    while (bus.out_valid !== 1'b1 && cyc < 60) begin
      @(posedge clk); #1; cyc++;
    end
    chk({tag, " latency"}, 32'(cyc), 32'(exp_lat));
    chk({tag, " a_out"}, 32'(bus.a_out), 32'(ea));
    chk({tag, " rem"}, 32'(bus.rem), 32'(er));
    chk({tag, " exact"}, 32'(bus.exact), 32'(ex));
    chk({tag, " err_div0"}, 32'(bus.err_div0), 32'(e0));
    for (int i = 0; i < hold; i++) begin
      if (pulse) begin
        bus.in_valid = 1'(i % 2 == 0);
        bus.d = 16'hBEEF; bus.b = 8'h55; bus.c = 8'h07; bus.s = 1'b0;
      end
      @(posedge clk); #1;
      chk({tag, " hold out_valid"}, 32'(bus.out_valid), 1);
      chk({tag, " hold in_ready"}, 32'(bus.in_ready), 0);
      chk({tag, " hold a_out"}, 32'(bus.a_out), 32'(ea));
      chk({tag, " hold rem"}, 32'(bus.rem), 32'(er));
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
    chk({tag, " out_valid after take"}, 32'(bus.out_valid), 0);
    chk({tag, " in_ready after take"}, 32'(bus.in_ready), 1);
    chk({tag, " a_out kept in idle"}, 32'(bus.a_out), 32'(ea));
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    vec_t        vecs[10];
    logic [7:0]  ra, rb, rc, ea, er;
    logic        rs, ex, e0;
    logic [15:0] rd;
    int          t;

    vecs[0] = '{16'h015E, 8'h34, 8'h05, 1'b1, 8'h12, 8'h00, 1'b1, 1'b0};
    vecs[1] = '{16'h00C0, 8'h10, 8'h03, 1'b0, 8'h50, 8'h00, 1'b1, 1'b0};
    vecs[2] = '{16'h0000, 8'h00, 8'h00, 1'b0, 8'h00, 8'h00, 1'b0, 1'b1};
    vecs[3] = '{16'h0101, 8'h00, 8'h10, 1'b1, 8'h10, 8'h01, 1'b0, 1'b0};
    vecs[4] = '{16'hFFFF, 8'h00, 8'h01, 1'b1, 8'hFF, 8'h00, 1'b0, 1'b0};
    vecs[5] = '{16'h01FF, 8'h01, 8'h01, 1'b1, 8'hFE, 8'h00, 1'b1, 1'b0};
    vecs[6] = '{16'h0200, 8'h00, 8'h01, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0};
    vecs[7] = '{16'hFFFF, 8'h00, 8'hFF, 1'b1, 8'h01, 8'h00, 1'b1, 1'b0};
    vecs[8] = '{16'hFFFE, 8'h00, 8'hFF, 1'b1, 8'h00, 8'hFE, 1'b0, 1'b0};
    vecs[9] = '{16'h1234, 8'h22, 8'h00, 1'b1, 8'h00, 8'h00, 1'b0, 1'b1};

    bus.in_valid = 1'b0; bus.out_ready = 1'b0;
    bus.d = '0; bus.b = '0; bus.c = '0; bus.s = 1'b0;

    repeat (3) @(posedge clk);
    #1;
    chk("reset in_ready", 32'(bus.in_ready), 1);
    chk("reset out_valid", 32'(bus.out_valid), 0);
    chk("reset a_out", 32'(bus.a_out), 0);
    chk("reset rem", 32'(bus.rem), 0);
    chk("reset exact", 32'(bus.exact), 0);
    chk("reset err_div0", 32'(bus.err_div0), 0);
    reset = 1'b1;
    @(posedge clk); #1;

    for (int i = 0; i < 10; i++) begin
      run_job($sformatf("vec%0d", i), vecs[i].d, vecs[i].b, vecs[i].c, vecs[i].s,
              vecs[i].a_exp, vecs[i].rem_exp, vecs[i].exact_exp, vecs[i].err_exp, 0, 1'b0);
    end

    // Backpressure in DONE with in_valid pulses that must be ignored.
    run_job("backpressure", 16'h015E, 8'h34, 8'h05, 1'b1, 8'h12, 8'h00, 1'b1, 1'b0, 5, 1'b1);

    // Reset in the middle of the division.
    bus.d = 16'h015E; bus.b = 8'h34; bus.c = 8'h05; bus.s = 1'b1; bus.in_valid = 1'b1;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    repeat (7) @(posedge clk);
    #2;
    reset = 1'b0;
    #1;
    chk("midreset out_valid", 32'(bus.out_valid), 0);
    chk("midreset in_ready", 32'(bus.in_ready), 1);
    chk("midreset a_out", 32'(bus.a_out), 0);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk); #1;
    run_job("after reset", 16'h015E, 8'h34, 8'h05, 1'b1, 8'h12, 8'h00, 1'b1, 1'b0, 0, 1'b0);

    // Randomized jobs against the reference model.
    for (int i = 0; i < 40; i++) begin
      ra = 8'($urandom);
      rb = 8'($urandom);
      rc = ($urandom_range(0, 15) == 0) ? 8'd0 : 8'($urandom_range(1, 255));
      rs = 1'($urandom);
      if (i % 2 == 0) begin
        t  = rs ? (int'(ra) + int'(rb)) : (int'(ra) - int'(rb));
        rd = 16'(t * int'(rc));
      end else begin
        rd = 16'($urandom);
      end
      model(rd, rb, rc, rs, ea, er, ex, e0);
      run_job($sformatf("rand%0d", i), rd, rb, rc, rs, ea, er, ex, e0,
              int'($urandom_range(0, 2)), 1'b0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
